// File: rtl/parking_slot_ctrl.sv
// parking_slot_ctrl: N-slot garage occupancy tracker with nearest-free-slot
// allocation, exit by slot number, door-open timer and reject/err pulses.
module parking_slot_ctrl #(
  parameter int N_SLOTS  = 8,
  parameter int SLOT_W   = $clog2(N_SLOTS),
  parameter int DOOR_CYC = 2000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                car_in,
  input  logic                car_out,
  input  logic [SLOT_W-1:0]   out_slot,
  output logic                door_open,
  output logic                full,
  output logic [SLOT_W:0]     free_count,
  output logic [SLOT_W-1:0]   near_slot,
  output logic [N_SLOTS-1:0]  occupancy,
  output logic                reject,
  output logic                err,
  output logic [1:0]          state
);

  localparam int TMR_W = $clog2(DOOR_CYC);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(DOOR_CYC - 1);
  localparam logic [SLOT_W:0] N_SLOTS_W = (SLOT_W + 1)'(N_SLOTS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ENTRY = 2'd1,
    EXIT  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [N_SLOTS-1:0] occupancy_q, occupancy_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic               reject_q, reject_d;
  logic               err_q, err_d;

  logic [SLOT_W:0]    occ_cnt;
  logic [N_SLOTS-1:0] exit_hit;   // one-hot of out_slot; all zero when out of range
  logic [N_SLOTS-1:0] near_hit;   // one-hot of near_slot
  logic               exit_legal;

  // One-hot decode of the requested exit slot and the allocation slot.
  // Indices >= N_SLOTS never match, so an out-of-range exit has no hit.
  for (genvar gi = 0; gi < N_SLOTS; gi++) begin : g_slot_dec
    assign exit_hit[gi] = (out_slot == SLOT_W'(gi));
    assign near_hit[gi] = (near_slot == SLOT_W'(gi));
  end

  assign exit_legal = |(exit_hit & occupancy_q);

  // Popcount of occupied slots at SLOT_W+1 bits so N_SLOTS is representable.
  always_comb begin
    occ_cnt = '0;
    for (int i = 0; i < N_SLOTS; i++) begin
      occ_cnt = occ_cnt + {{SLOT_W{1'b0}}, occupancy_q[i]};
    end
  end

  // Lowest-index free slot; scanning downward lets the lowest zero win.
  always_comb begin
    near_slot = '0;
    for (int i = N_SLOTS - 1; i >= 0; i--) begin
      if (!occupancy_q[i]) begin
        near_slot = SLOT_W'(i);
      end
    end
  end

  assign free_count = N_SLOTS_W - occ_cnt;
  assign full       = (free_count == '0);
  assign door_open  = (state_q != IDLE);
  assign occupancy  = occupancy_q;
  assign reject     = reject_q;
  assign err        = err_q;
  assign state      = state_q;

  // Next-state logic: exit beats entry; an illegal exit still lets the
  // same-cycle entry be evaluated. Requests outside IDLE are ignored.
  always_comb begin
    state_d     = state_q;
    occupancy_d = occupancy_q;
    timer_d     = timer_q;
    reject_d    = 1'b0;
    err_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (car_out) begin
          if (exit_legal) begin
            occupancy_d = occupancy_q & ~exit_hit;
            timer_d     = TMR_LOAD;
            state_d     = EXIT;
          end else begin
            err_d = 1'b1;
          end
        end
        if (car_in && !(car_out && exit_legal)) begin
          if (full) begin
            reject_d = 1'b1;
          end else begin
            occupancy_d = occupancy_q | near_hit;
            timer_d     = TMR_LOAD;
            state_d     = ENTRY;
          end
        end
      end
      ENTRY, EXIT: begin
        if (timer_q == '0) begin
          state_d = IDLE;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, occupancy, timer and pulse flops with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      occupancy_q <= '0;
      timer_q     <= '0;
      reject_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      occupancy_q <= occupancy_d;
      timer_q     <= timer_d;
      reject_q    <= reject_d;
      err_q       <= err_d;
    end
  end

endmodule
